// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse-train engine: default widths and FSM state encoding.
// Also imported by the board-level config decoder.
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF    = 32;
  localparam int NPULSE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pg_state_t;

endpackage

// File: rtl/pulse_train_gen_pg_downcnt.sv
// Loadable down-counter that saturates at zero and flags it.
// Used as the single phase timer of the pulse-train engine.
module pg_downcnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train engine: delay, then N pulses of width W every P cycles.
// One shared down-counter times every phase; it is reloaded with (length-1) on entry.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NPULSE_W = NPULSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    cfg_delay,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [NPULSE_W-1:0] cfg_npulse,
  input  logic                trig,
  input  logic                stop,
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic [NPULSE_W-1:0] pulse_cnt
);

  pg_state_t state_reg;

  logic [CNT_W-1:0]    w_reg;
  logic [CNT_W-1:0]    p_reg;
  logic [NPULSE_W-1:0] n_reg;

  logic [CNT_W-1:0] p_eff;
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] first_len;
  logic             accept;
  logic             last_pulse;
  logic             start_pulse;
  logic             end_high;
  logic             end_burst;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Operand clamping happens on the live config so the shadows hold legal values only.
  assign p_eff = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
  assign w_eff = (cfg_width < p_eff) ? cfg_width : p_eff - CNT_W'(1);

  assign accept      = (state_reg == ST_IDLE) && trig && !stop;
  assign last_pulse  = (n_reg != '0) && (pulse_cnt == n_reg);
  assign start_pulse = !stop && cnt_zero &&
                       ((state_reg == ST_DELAY) || ((state_reg == ST_LOW) && !last_pulse));
  assign end_high    = !stop && cnt_zero && (state_reg == ST_HIGH);
  assign end_burst   = !stop && cnt_zero && (state_reg == ST_LOW) && last_pulse;

  // With W=0 the period is a single LOW phase of P cycles.
  assign first_len = (w_reg != '0) ? w_reg - CNT_W'(1) : p_reg - CNT_W'(1);

  // The accept cycle is the first delay cycle, so loading D (not D-1) puts
  // the first rise D+1 edges after accept without needing a wider counter.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (accept) begin
      cnt_load = 1'b1;
      cnt_val  = cfg_delay;
    end else if (start_pulse) begin
      cnt_load = 1'b1;
      cnt_val  = first_len;
    end else if (end_high) begin
      cnt_load = 1'b1;
      cnt_val  = p_reg - w_reg - CNT_W'(1);
    end
  end

  pg_downcnt #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      w_reg     <= '0;
      p_reg     <= '0;
      n_reg     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (accept) begin
          state_reg <= ST_DELAY;
          busy      <= 1'b1;
          pulse_cnt <= '0;
          w_reg     <= w_eff;
          p_reg     <= p_eff;
          n_reg     <= cfg_npulse;
        end
      end else if (stop) begin
        state_reg <= ST_IDLE;
        busy      <= 1'b0;
        pulse_out <= 1'b0;
      end else if (start_pulse) begin
        pulse_cnt <= pulse_cnt + NPULSE_W'(1);
        if (w_reg != '0) begin
          state_reg <= ST_HIGH;
          pulse_out <= 1'b1;
        end else begin
          state_reg <= ST_LOW;
        end
      end else if (end_high) begin
        state_reg <= ST_LOW;
        pulse_out <= 1'b0;
      end else if (end_burst) begin
        state_reg <= ST_IDLE;
        busy      <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized bench for pulse_train_gen against a timeline model: outputs are
// derived from the number of cycles elapsed since trigger accept.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_delay, cfg_width, cfg_period;
  logic [15:0] cfg_npulse;
  logic        trig, stop;
  logic        pulse_out, busy, done;
  logic [15:0] pulse_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: burst timeline position and captured operands.
  bit     m_act;
  bit     m_done;
  longint m_k, m_D, m_W, m_P, m_N;
  longint m_cnt_last;

  always #5 clk = ~clk;

  pulse_train_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_npulse (cfg_npulse),
    .trig       (trig),
    .stop       (stop),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint exp_cnt();
    longint j;
    if (!m_act) return m_cnt_last;
    j = m_k - 1 - m_D;
    if (j < 0) return 0;
    return ((j / m_P) + 1) % 65536;
  endfunction

  function automatic longint exp_pulse();
    longint j;
    if (!m_act) return 0;
    j = m_k - 1 - m_D;
    if (j < 0) return 0;
    return ((j % m_P) < m_W) ? 1 : 0;
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (!rst_n) begin
      m_act      = 1'b0;
      m_cnt_last = 0;
    end else if (!m_act) begin
      if (trig && !stop) begin
        m_act = 1'b1;
        m_k   = 0;
        m_D   = longint'(cfg_delay);
        m_P   = (cfg_period < 2) ? 2 : longint'(cfg_period);
        m_W   = (longint'(cfg_width) < m_P - 1) ? longint'(cfg_width) : m_P - 1;
        m_N   = longint'(cfg_npulse);
        $display("start  D=%0d W=%0d P=%0d N=%0d", m_D, m_W, m_P, m_N);
      end
    end else if (stop) begin
      m_cnt_last = exp_cnt();
      m_act      = 1'b0;
      $display("abort  k=%0d pulse_cnt=%0d", m_k, m_cnt_last);
    end else begin
      m_k++;
      if (m_N != 0 && m_k == 1 + m_D + m_N * m_P) begin
        m_act      = 1'b0;
        m_done     = 1'b1;
        m_cnt_last = m_N;
        $display("done   k=%0d pulse_cnt=%0d", m_k, m_N);
      end
    end
    #1;
    check("busy",      busy,      m_act);
    check("done",      done,      m_done);
    check("pulse_out", pulse_out, exp_pulse());
    check("pulse_cnt", pulse_cnt, exp_cnt());
  endtask

  // Start a burst with a 1-cycle trig; stop (if stop_k>=0) during model cycle stop_k.
  task automatic run_burst(input longint d, input longint w, input longint p, input longint n,
                           input longint stop_k, input bit scramble);
    int guard;
    cfg_delay  = 32'(d);
    cfg_width  = 32'(w);
    cfg_period = 32'(p);
    cfg_npulse = 16'(n);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    guard = 0;
    while (m_act && guard < 2000) begin
      stop = (stop_k >= 0 && m_k == stop_k);
      if (scramble) begin
        cfg_delay  = 32'($urandom_range(0, 9));
        cfg_width  = 32'($urandom_range(0, 9));
        cfg_period = 32'($urandom_range(0, 9));
        cfg_npulse = 16'($urandom_range(0, 5));
      end
      tick();
      stop  = 1'b0;
      guard++;
    end
    check("burst_bound", (guard < 2000) ? 1 : 0, 1);
  endtask

  initial begin
    longint d, w, p, n, sk;
    int     guard;
    rst_n = 1'b0; trig = 1'b0; stop = 1'b0;
    cfg_delay = '0; cfg_width = '0; cfg_period = '0; cfg_npulse = '0;
    m_act = 1'b0; m_done = 1'b0; m_cnt_last = 0; m_k = 0;
    m_D = 0; m_W = 0; m_P = 2; m_N = 0;
    #2;
    check("rst_busy",  busy,      0);
    check("rst_done",  done,      0);
    check("rst_pulse", pulse_out, 0);
    check("rst_cnt",   pulse_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_burst(0, 3, 10, 4, -1, 1'b0);
    run_burst(5, 1, 2, 2, -1, 1'b0);
    run_burst(0, 8, 8, 2, -1, 1'b0);
    run_burst(1, 0, 5, 3, -1, 1'b0);
    run_burst(0, 2, 4, 0, 9, 1'b0);
    check("abort_cnt", pulse_cnt, 3);
    tick();

    // Level trig across bursts: each done cycle re-triggers.
    cfg_delay = 0; cfg_width = 1; cfg_period = 4; cfg_npulse = 1;
    trig = 1'b1;
    repeat (20) tick();
    trig = 1'b0;
    guard = 0;
    while (m_act && guard < 100) begin tick(); guard++; end
    trig = 1'b1; stop = 1'b1;
    repeat (2) tick();
    trig = 1'b0; stop = 1'b0;
    check("trig_stop_idle", busy, 0);

    // Asynchronous reset while high.
    cfg_delay = 0; cfg_width = 3; cfg_period = 8; cfg_npulse = 0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pulse", pulse_out, 0);
    check("async_rst_busy",  busy,      0);
    check("async_rst_cnt",   pulse_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_burst(2, 3, 6, 3, -1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 9);
      p = $urandom_range(0, 10);
      n = $urandom_range(0, 4);
      if (n == 0 || $urandom_range(0, 3) == 0)
        sk = $urandom_range(0, 1 + d + 4 * ((p < 2) ? 2 : p));
      else
        sk = -1;
      run_burst(d, w, p, n, sk, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
